// File: rtl/bin2bcd_seq.sv
// Sequential 27-bit binary to 8-digit BCD converter (shift-add-3, one bit per clock).
// Out-of-range inputs (> 99,999,999) saturate the display to all nines and raise ovf.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [26:0] bin,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic [3:0]  digit5,
  output logic [3:0]  digit6,
  output logic [3:0]  digit7,
  output logic [3:0]  digit8,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  localparam logic [26:0] MAX_BIN   = 27'd99_999_999;
  localparam logic [4:0]  N_ITER    = 5'd27;
  localparam logic [31:0] ALL_NINES = 32'h9999_9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [26:0] shift_q;
  logic [31:0] acc_q;
  logic [4:0]  cnt_q;
  logic        ovf_pend_q;
  logic [31:0] digits_q;
  logic        ovf_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] acc_adj;
  logic [31:0] acc_next;
  logic        accept;
  logic        last_iter;
  logic        busy_d;
  logic        done_d;

  // Each nibble >= 5 gets +3 so the following doubling carries into the next decade.
  function automatic logic [31:0] add3(input logic [31:0] a);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < 8; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    acc_adj   = add3(acc_q);
    acc_next  = {acc_adj[30:0], shift_q[26]};
    // DONE's exit edge also accepts start, so held-high requests recur every 28 edges.
    accept    = start && (state != CONV);
    last_iter = (state == CONV) && (cnt_q == 5'd1);
  end

  // ---------------------------------------------------------------- state register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CONV;
      CONV:    if (last_iter) next_state = DONE;
      DONE:    next_state = start ? CONV : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Decoded from next_state and then registered, so busy/done line up with the state flops.
  always_comb begin
    busy_d = (next_state == CONV);
    done_d = (next_state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
    end else if (accept) begin
      shift_q    <= bin;
      acc_q      <= '0;
      cnt_q      <= N_ITER;
      ovf_pend_q <= (bin > MAX_BIN);
    end else if (state == CONV) begin
      acc_q   <= acc_next;
      shift_q <= {shift_q[25:0], 1'b0};
      cnt_q   <= cnt_q - 5'd1;
      if (last_iter) begin
        digits_q <= ovf_pend_q ? ALL_NINES : acc_next;
        ovf_q    <= ovf_pend_q;
      end
    end
  end

  assign digit1 = digits_q[3:0];
  assign digit2 = digits_q[7:4];
  assign digit3 = digits_q[11:8];
  assign digit4 = digits_q[15:12];
  assign digit5 = digits_q[19:16];
  assign digit6 = digits_q[23:20];
  assign digit7 = digits_q[27:24];
  assign digit8 = digits_q[31:28];
  assign busy   = busy_q;
  assign done   = done_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed table, back-to-back, reset abort
// and randomized conversions against an arithmetic decimal-expansion model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [26:0] bin;
  logic [3:0]  digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8;
  logic        busy, done, ovf;
  logic [31:0] dut_digits;

  int n_checks = 0;
  int n_fail   = 0;
  int starts_n = 0;
  int dones_n  = 0;
  int bad_bcd  = 0;

  logic [31:0] prev_d;
  logic        prev_o;

  typedef struct {
    string       name;
    logic [26:0] bin;
    logic [31:0] digits;
    logic        ovf;
  } vec_t;

  vec_t vecs [7];

  bin2bcd_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bin    (bin),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .digit4 (digit4),
    .digit5 (digit5),
    .digit6 (digit6),
    .digit7 (digit7),
    .digit8 (digit8),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf)
  );

  assign dut_digits = {digit8, digit7, digit6, digit5, digit4, digit3, digit2, digit1};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain decimal expansion, saturating to all nines above 99,999,999.
  function automatic logic [31:0] ref_bcd(input longint unsigned v);
    logic [31:0] r;
    longint unsigned t;
    r = '0;
    if (v > 64'd99_999_999) return 32'h9999_9999;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int count_bad_nibbles(input logic [31:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) if (d[4*i +: 4] > 4'd9) n++;
    return n;
  endfunction

  // Called at a negedge; start is accepted at the next posedge (edge N).
  // Returns at the negedge after edge N+27, so a following call lands on edge N+28.
  task automatic run_conv(input logic [26:0] b, input logic [31:0] exp_d,
                          input logic exp_o, input string tag);
    int          busy_n;
    int          done_early;
    logic [31:0] mid_d;
    logic        mid_o;
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    starts_n++;
    @(negedge clk);
    start      = 1'b0;
    bin        = 27'($urandom);
    busy_n     = int'(busy);
    done_early = int'(done);
    mid_d      = '0;
    mid_o      = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 27) begin
        busy_n     += int'(busy);
        done_early += int'(done);
      end
      if (done) dones_n++;
      bad_bcd += count_bad_nibbles(dut_digits);
      if (k == 13) begin
        mid_d = dut_digits;
        mid_o = ovf;
      end
    end
    check({tag, " busy cycles"}, 64'(busy_n), 64'd27);
    check({tag, " early done"}, 64'(done_early), 64'd0);
    check({tag, " busy/done at N+27"}, {62'd0, busy, done}, 64'b01);
    check({tag, " digits held"}, 64'(mid_d), 64'(prev_d));
    check({tag, " ovf held"}, 64'(mid_o), 64'(prev_o));
    check({tag, " digits"}, 64'(dut_digits), 64'(exp_d));
    check({tag, " ovf"}, 64'(ovf), 64'(exp_o));
    prev_d = exp_d;
    prev_o = exp_o;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [26:0] bin_seq [0:84];
    int          timing_err;
    int          abort_err;
    logic [26:0] rb;

    vecs[0] = '{"v12345678", 27'd12_345_678,  32'h1234_5678, 1'b0};
    vecs[1] = '{"vzero",     27'd0,           32'h0000_0000, 1'b0};
    vecs[2] = '{"vmax",      27'd99_999_999,  32'h9999_9999, 1'b0};
    vecs[3] = '{"v1e8",      27'd100_000_000, 32'h9999_9999, 1'b1};
    vecs[4] = '{"vfull",     27'd134_217_727, 32'h9999_9999, 1'b1};
    vecs[5] = '{"vseven",    27'd7,           32'h0000_0007, 1'b0};
    vecs[6] = '{"v10203",    27'd10_203,      32'h0001_0203, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    #3;
    check("reset digits", 64'(dut_digits), 64'd0);
    check("reset busy/done/ovf", {61'd0, busy, done, ovf}, 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    prev_d = '0;
    prev_o = 1'b0;
    idle_cycle();

    // Directed table, run back-to-back.
    for (int i = 0; i < 7; i++) run_conv(vecs[i].bin, vecs[i].digits, vecs[i].ovf, vecs[i].name);
    idle_cycle();
    check("done drops after N+28", 64'(done), 64'd0);

    // start held high, bin changing every cycle: accepts at edges 0, 28, 56 only.
    timing_err = 0;
    for (int c = 0; c <= 84; c++) begin
      bin_seq[c] = 27'($urandom_range(99_999_999));
      bin   = bin_seq[c];
      start = (c < 84);
      @(posedge clk);
      @(negedge clk);
      if (c == 84) begin
        if (busy !== 1'b0 || done !== 1'b0) timing_err++;
      end else if (c % 28 == 27) begin
        if (busy !== 1'b0 || done !== 1'b1) timing_err++;
        check($sformatf("held result @%0d", c), 64'(dut_digits), 64'(ref_bcd(64'(bin_seq[c-27]))));
      end else begin
        if (busy !== 1'b1 || done !== 1'b0) timing_err++;
      end
    end
    start = 1'b0;
    check("held start timing errors", 64'(timing_err), 64'd0);
    prev_d = ref_bcd(64'(bin_seq[56]));
    prev_o = 1'b0;
    idle_cycle();

    // Reset asserted at edge N+10 of a conversion: outputs clear at once, no done follows.
    start = 1'b1;
    bin   = 27'd55_555_555;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("async reset digits", 64'(dut_digits), 64'd0);
    check("async reset busy/done/ovf", {61'd0, busy, done, ovf}, 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    abort_err = 0;
    for (int c = 0; c < 30; c++) begin
      idle_cycle();
      if (done !== 1'b0 || busy !== 1'b0 || dut_digits !== 32'd0) abort_err++;
    end
    check("aborted conversion quiet", 64'(abort_err), 64'd0);
    prev_d = '0;
    prev_o = 1'b0;
    run_conv(27'd42, 32'h0000_0042, 1'b0, "after reset");

    // Randomized conversions against the reference model.
    starts_n = 0;
    dones_n  = 0;
    bad_bcd  = 0;
    for (int i = 0; i < 1000; i++) begin
      rb = 27'($urandom_range(99_999_999));
      if (i % 50 == 7) idle_cycle();
      run_conv(rb, ref_bcd(64'(rb)), 1'b0, $sformatf("rand%0d bin=%0d", i, rb));
    end
    check("done count vs accepted starts", 64'(dones_n), 64'(starts_n));
    check("illegal BCD nibbles seen", 64'(bad_bcd), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
